trav_decide: RTL and testbench
==============================

// Module: trav_decide
// PURPOSE
//  Consumes trav_math's per-ray case flags, t_min/t_max/t_mid and node data, then forms the next kd-tree step:
//  the near child to traverse and an optional far-child stack push. trav_math's pipeline cannot stall, so results
//  land in an elastic FIFO. The FIFO drains to the traversal scheduler over valid/ready and throttles issue via almost_full.
// PARAMETERS
//  DEPTH     32  FIFO entries (power of 2, >=4)
//  SLACK     14  almost_full asserts when free entries <= SLACK (covers trav_math latency + 1)
//  NODE_W    16  node index width
//  RAY_W      9  ray id width
// PORTS
//  clk              in   1        clock
//  rst              in   1        synchronous active-high reset
//  in_valid         in   1        trav_math results valid this cycle (aligned with flags)
//  in_ray_id        in   RAY_W    ray id
//  in_low_child     in   NODE_W   index of low child; high child = low_child+1
//  only_low         in   1        trav_math flag
//  only_high        in   1        trav_math flag
//  trav_lo_then_hi  in   1        trav_math flag
//  trav_hi_then_lo  in   1        trav_math flag
//  t_min_in         in   32       float_t
//  t_max_in         in   32       float_t
//  t_mid_in         in   32       float_t
//  almost_full      out  1        upstream must not issue new rays while high
//  out_valid        out  1        head entry valid
//  out_ready        in   1        consumer accepts head
//  out_data         out  trav_dec_t  {ray_id, next_node, t_min, t_max, push_v, push_node, push_t_min, push_t_max}
//  overflow_err     out  1        sticky: write attempted while full
//  flag_err         out  1        sticky: zero or >1 case flags on a valid input
// BEHAVIOUR
//  Reset: FIFO empty, out_valid=0, out_data=0, almost_full=0, overflow_err=0, flag_err=0, stats cleared.
//  Decode, combinational on input; priority lo_then_hi > hi_then_lo > only_low > only_high:
//   lo_then_hi: next=low,  t_min=t_min_in, t_max=t_mid; push_v=1, push=high, [t_mid, t_max_in]
//   hi_then_lo: next=high, t_min=t_min_in, t_max=t_mid; push_v=1, push=low,  [t_mid, t_max_in]
//   only_low / only_high: next=low/high, t_min/t_max unchanged, push_v=0, push fields 0
//   no flag set: decode as only_low; set flag_err. More than one flag set: priority applies; set flag_err.
//  Write: in_valid & ~full writes the entry at the rising edge. out_valid rises the next cycle (1-cycle latency when empty).
//  Read: out_valid & out_ready pops head. out_data is driven from head storage and is stable while out_valid & ~out_ready.
//  Simultaneous push+pop: allowed at any occupancy, including full and empty-with-bypass-off; count unchanged.
//  in_valid while full and no pop in that cycle: entry dropped, overflow_err set, count unchanged.
//  Pointers: log2(DEPTH) bits plus a wrap bit; full/empty from the wrap-bit compare; wrap-around at DEPTH-1 -> 0.
//  almost_full registered: reflects next-cycle count, (DEPTH - count_next) <= SLACK.
//  in_low_child+1 wraps modulo 2^NODE_W. Float fields pass through unmodified; no arithmetic.
//  rst mid-operation: all in-flight entries discarded; state returns to reset values next cycle.
// CONFIGURATION
//  TRAV_DECIDE_STATS_EN defined: four 32-bit saturating counters (cnt_low, cnt_high, cnt_lohi, cnt_hilo) count
//   decoded cases on accepted writes; exposed as output port stats (4x32). Cleared by rst.
//  TRAV_DECIDE_STATS_EN undefined: counters and the stats port are absent; all other behaviour is identical.
// STRUCTURE
//  Shared raytracer package: float_t (already defined there), new packed struct trav_dec_t, and enum
//   trav_case_e {TC_LOW, TC_HIGH, TC_LOHI, TC_HILO}.
//  One sub-module: trav_fifo (parameterised DEPTH/WIDTH synchronous FIFO with count and almost_full).
//   Decode logic stays in trav_decide.
// TESTING
//  1 lo_then_hi, low_child=0x0010, t_min=1.0, t_mid=2.0, t_max=5.0 -> next=0x0010, [1.0,2.0], push_v=1,
//    push=0x0011, [2.0,5.0]; out_valid one cycle after in_valid.
//  2 only_high, low_child=0xFFFF -> next=0x0000 (wrap), push_v=0, t_min/t_max unchanged.
//  3 out_ready=0 with 32 back-to-back writes -> almost_full high once free<=14; 33rd write dropped and
//    overflow_err=1; draining returns all 32 entries in order.
//  4 full FIFO: in_valid and out_ready in the same cycle -> count stays 32, no error, order kept.
//  5 all flags 0, then two flags (only_low+only_high) -> both decoded as only_low; flag_err=1 and sticky.
//  6 rst asserted with 10 entries queued -> next cycle out_valid=0, almost_full=0; with
//    TRAV_DECIDE_STATS_EN defined, counters read 0.

Source files
------------

// File: rtl/trav_decide_pkg.sv
// Shared raytracer types for the kd-tree traversal decision stage:
// float_t, the decoded-step record trav_dec_t and the traversal case enum.
package trav_decide_pkg;

  localparam int NODE_W = 16;
  localparam int RAY_W  = 9;

  typedef logic [31:0] float_t;

  typedef enum logic [1:0] {
    TC_LOW  = 2'd0,
    TC_HIGH = 2'd1,
    TC_LOHI = 2'd2,
    TC_HILO = 2'd3
  } trav_case_e;

  typedef struct packed {
    logic [RAY_W-1:0]  ray_id;
    logic [NODE_W-1:0] next_node;
    float_t            t_min;
    float_t            t_max;
    logic              push_v;
    logic [NODE_W-1:0] push_node;
    float_t            push_t_min;
    float_t            push_t_max;
  } trav_dec_t;

  localparam int TRAV_DEC_W = $bits(trav_dec_t);

endpackage

// File: rtl/trav_fifo.sv
// Synchronous FIFO with wrap-bit pointers, same-cycle push+pop at any occupancy
// and a registered almost_full computed from the next-cycle occupancy.
module trav_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int SLACK = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             wr_accept,
  output logic             wr_drop,
  output logic             almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] SLACK_V = (AW+1)'(SLACK);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [AW:0] count_next, free_next;
  logic        do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot being written, so a full FIFO may still accept.
  assign do_rd     = rd_req & ~empty;
  assign wr_accept = wr_req & (~full | do_rd);
  assign wr_drop   = wr_req & full & ~do_rd;

  assign wr_ptr_next = wr_ptr + (AW+1)'(wr_accept);
  assign rd_ptr_next = rd_ptr + (AW+1)'(do_rd);
  assign count_next  = wr_ptr_next - rd_ptr_next;
  assign free_next   = DEPTH_V - count_next;

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      almost_full <= (free_next <= SLACK_V);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/trav_decide.sv
// Decodes trav_math case flags into the next kd-tree step plus optional far-child push
// and queues results in trav_fifo. Define TRAV_DECIDE_STATS_EN to add per-case counters.
module trav_decide
  import trav_decide_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int SLACK = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [RAY_W-1:0]  in_ray_id,
  input  logic [NODE_W-1:0] in_low_child,
  input  logic              only_low,
  input  logic              only_high,
  input  logic              trav_lo_then_hi,
  input  logic              trav_hi_then_lo,
  input  logic [31:0]       t_min_in,
  input  logic [31:0]       t_max_in,
  input  logic [31:0]       t_mid_in,
  output logic              almost_full,
  output logic              out_valid,
  input  logic              out_ready,
  output trav_dec_t         out_data,
`ifdef TRAV_DECIDE_STATS_EN
  output logic [3:0][31:0]  stats,
`endif
  output logic              overflow_err,
  output logic              flag_err
);

  trav_case_e        dec_case;
  trav_dec_t         dec;
  logic [NODE_W-1:0] high_child;
  logic              flags_bad;
  logic              empty, full, wr_accept, wr_drop;

  assign high_child = in_low_child + NODE_W'(1);
  assign flags_bad  = ($countones({trav_lo_then_hi, trav_hi_then_lo, only_low, only_high}) != 1);

  // No flag set falls through to the low child; multiple flags resolve by priority.
  always_comb begin
    dec_case = TC_LOW;
    if (trav_lo_then_hi)      dec_case = TC_LOHI;
    else if (trav_hi_then_lo) dec_case = TC_HILO;
    else if (only_low)        dec_case = TC_LOW;
    else if (only_high)       dec_case = TC_HIGH;
  end

  always_comb begin
    dec           = '0;
    dec.ray_id    = in_ray_id;
    dec.next_node = in_low_child;
    dec.t_min     = t_min_in;
    dec.t_max     = t_max_in;
    unique case (dec_case)
      TC_HIGH: dec.next_node = high_child;
      TC_LOHI: begin
        dec.t_max      = t_mid_in;
        dec.push_v     = 1'b1;
        dec.push_node  = high_child;
        dec.push_t_min = t_mid_in;
        dec.push_t_max = t_max_in;
      end
      TC_HILO: begin
        dec.next_node  = high_child;
        dec.t_max      = t_mid_in;
        dec.push_v     = 1'b1;
        dec.push_node  = in_low_child;
        dec.push_t_min = t_mid_in;
        dec.push_t_max = t_max_in;
      end
      default: ;
    endcase
  end

  trav_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(TRAV_DEC_W),
    .SLACK(SLACK)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (in_valid),
    .wr_data    (dec),
    .rd_req     (out_ready),
    .rd_data    (out_data),
    .empty      (empty),
    .full       (full),
    .wr_accept  (wr_accept),
    .wr_drop    (wr_drop),
    .almost_full(almost_full)
  );

  assign out_valid = ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_err <= 1'b0;
      flag_err     <= 1'b0;
    end else begin
      if (wr_drop)               overflow_err <= 1'b1;
      if (in_valid && flags_bad) flag_err     <= 1'b1;
    end
  end

`ifdef TRAV_DECIDE_STATS_EN
  // Saturating so a long run never wraps back to a misleadingly small count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stats <= '0;
    end else if (wr_accept && stats[dec_case] != 32'hFFFF_FFFF) begin
      stats[dec_case] <= stats[dec_case] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trav_decide.sv
// Directed self-checking bench for trav_decide; stats checks compile in when
// TRAV_DECIDE_STATS_EN is defined.
module tb_trav_decide;
  import trav_decide_pkg::*;

  localparam float_t ONE   = 32'h3F80_0000;
  localparam float_t TWO   = 32'h4000_0000;
  localparam float_t THREE = 32'h4040_0000;
  localparam float_t FOUR  = 32'h4080_0000;
  localparam float_t FIVE  = 32'h40A0_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [RAY_W-1:0]  in_ray_id;
  logic [NODE_W-1:0] in_low_child;
  logic              only_low, only_high, trav_lo_then_hi, trav_hi_then_lo;
  logic [31:0]       t_min_in, t_max_in, t_mid_in;
  logic              almost_full, out_valid, out_ready;
  trav_dec_t         out_data;
  logic              overflow_err, flag_err;
`ifdef TRAV_DECIDE_STATS_EN
  logic [3:0][31:0]  stats;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trav_decide dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ray_id      (in_ray_id),
    .in_low_child   (in_low_child),
    .only_low       (only_low),
    .only_high      (only_high),
    .trav_lo_then_hi(trav_lo_then_hi),
    .trav_hi_then_lo(trav_hi_then_lo),
    .t_min_in       (t_min_in),
    .t_max_in       (t_max_in),
    .t_mid_in       (t_mid_in),
    .almost_full    (almost_full),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
`ifdef TRAV_DECIDE_STATS_EN
    .stats          (stats),
`endif
    .overflow_err   (overflow_err),
    .flag_err       (flag_err)
  );

  task automatic checkOutput(input string tag, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // flags = {lo_then_hi, hi_then_lo, only_low, only_high}
  task automatic applyStimulus(input logic v, input logic [RAY_W-1:0] ray, input logic [NODE_W-1:0] low,
                               input logic [3:0] f, input float_t tmn, input float_t tmx, input float_t tmd);
    in_valid     = v;
    in_ray_id    = ray;
    in_low_child = low;
    {trav_lo_then_hi, trav_hi_then_lo, only_low, only_high} = f;
    t_min_in     = tmn;
    t_max_in     = tmx;
    t_mid_in     = tmd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    applyStimulus(1'b0, '0, '0, 4'b0000, '0, '0, '0);
  endtask

  task automatic popOne;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [RAY_W-1:0] exp_ray;

    rst = 1'b1;
    out_ready = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset out_valid", 256'(out_valid), 256'(0));
    checkOutput("reset almost_full", 256'(almost_full), 256'(0));
    checkOutput("reset overflow_err", 256'(overflow_err), 256'(0));
    checkOutput("reset flag_err", 256'(flag_err), 256'(0));
    checkOutput("reset out_data", 256'(out_data), 256'(0));

    // lo_then_hi
    applyStimulus(1'b1, 9'd1, 16'h0010, 4'b1000, ONE, FIVE, TWO);
    checkOutput("t1 not yet valid", 256'(out_valid), 256'(0));
    tick();
    idle();
    checkOutput("t1 out_valid", 256'(out_valid), 256'(1));
    checkOutput("t1 ray", 256'(out_data.ray_id), 256'(1));
    checkOutput("t1 next", 256'(out_data.next_node), 256'(16'h0010));
    checkOutput("t1 t_min", 256'(out_data.t_min), 256'(ONE));
    checkOutput("t1 t_max", 256'(out_data.t_max), 256'(TWO));
    checkOutput("t1 push_v", 256'(out_data.push_v), 256'(1));
    checkOutput("t1 push_node", 256'(out_data.push_node), 256'(16'h0011));
    checkOutput("t1 push_t_min", 256'(out_data.push_t_min), 256'(TWO));
    checkOutput("t1 push_t_max", 256'(out_data.push_t_max), 256'(FIVE));
    popOne();
    checkOutput("t1 drained", 256'(out_valid), 256'(0));

    // hi_then_lo
    applyStimulus(1'b1, 9'd2, 16'h0100, 4'b0100, ONE, FIVE, TWO);
    tick();
    idle();
    checkOutput("hilo next", 256'(out_data.next_node), 256'(16'h0101));
    checkOutput("hilo t_max", 256'(out_data.t_max), 256'(TWO));
    checkOutput("hilo push_node", 256'(out_data.push_node), 256'(16'h0100));
    checkOutput("hilo push range", 256'({out_data.push_v, out_data.push_t_min, out_data.push_t_max}),
                256'({1'b1, TWO, FIVE}));
    popOne();

    // only_high with child index wrap
    applyStimulus(1'b1, 9'd3, 16'hFFFF, 4'b0001, THREE, FOUR, TWO);
    tick();
    idle();
    checkOutput("t2 next wrap", 256'(out_data.next_node), 256'(16'h0000));
    checkOutput("t2 t range", 256'({out_data.t_min, out_data.t_max}), 256'({THREE, FOUR}));
    checkOutput("t2 push fields", 256'({out_data.push_v, out_data.push_node, out_data.push_t_min, out_data.push_t_max}),
                256'(0));
    popOne();

    // Fill to full with the consumer stalled
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, RAY_W'(i), NODE_W'(i * 2), 4'b0010, ONE, FIVE, TWO);
      tick();
      checkOutput($sformatf("t3 almost_full n=%0d", i + 1), 256'(almost_full), 256'((i + 1) >= 18));
    end
    idle();
    checkOutput("t3 head stable ray", 256'(out_data.ray_id), 256'(0));
    checkOutput("t3 head stable node", 256'(out_data.next_node), 256'(0));
    checkOutput("t3 no overflow yet", 256'(overflow_err), 256'(0));

    // Push and pop together while full
    applyStimulus(1'b1, 9'd100, 16'h0200, 4'b0010, ONE, FIVE, TWO);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    idle();
    checkOutput("t4 no overflow", 256'(overflow_err), 256'(0));
    checkOutput("t4 head advanced", 256'(out_data.ray_id), 256'(1));
    checkOutput("t4 almost_full", 256'(almost_full), 256'(1));

    // 33rd write with no pop is dropped
    applyStimulus(1'b1, 9'd200, 16'h0300, 4'b0010, ONE, FIVE, TWO);
    tick();
    idle();
    checkOutput("t3 overflow_err", 256'(overflow_err), 256'(1));

    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      exp_ray = (k < 31) ? RAY_W'(k + 1) : 9'd100;
      checkOutput($sformatf("drain valid %0d", k), 256'(out_valid), 256'(1));
      checkOutput($sformatf("drain ray %0d", k), 256'(out_data.ray_id), 256'(exp_ray));
      tick();
    end
    out_ready = 1'b0;
    checkOutput("drain empty", 256'(out_valid), 256'(0));
    checkOutput("drain almost_full", 256'(almost_full), 256'(0));
    checkOutput("overflow sticky", 256'(overflow_err), 256'(1));

    // Flag errors
    checkOutput("t5 flag_err clear", 256'(flag_err), 256'(0));
    applyStimulus(1'b1, 9'd5, 16'h0020, 4'b0000, ONE, FIVE, TWO);
    tick();
    idle();
    checkOutput("t5 zero flags err", 256'(flag_err), 256'(1));
    checkOutput("t5 zero flags next", 256'(out_data.next_node), 256'(16'h0020));
    checkOutput("t5 zero flags decode", 256'({out_data.push_v, out_data.t_max}), 256'({1'b0, FIVE}));
    popOne();
    applyStimulus(1'b1, 9'd6, 16'h0030, 4'b0011, ONE, FIVE, TWO);
    tick();
    idle();
    checkOutput("t5 two flags next", 256'(out_data.next_node), 256'(16'h0030));
    checkOutput("t5 two flags push_v", 256'(out_data.push_v), 256'(0));
    popOne();
    applyStimulus(1'b1, 9'd7, 16'h0040, 4'b0001, ONE, FIVE, TWO);
    tick();
    idle();
    checkOutput("t5 flag_err sticky", 256'(flag_err), 256'(1));
    checkOutput("t5 good next", 256'(out_data.next_node), 256'(16'h0041));
    popOne();

    // Reset with entries in flight
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, RAY_W'(i + 50), NODE_W'(i), 4'b0010, ONE, FIVE, TWO);
      tick();
    end
    idle();
    checkOutput("t6 queued", 256'(out_valid), 256'(1));
`ifdef TRAV_DECIDE_STATS_EN
    checkOutput("stats low", 256'(stats[TC_LOW]), 256'(45));
    checkOutput("stats high", 256'(stats[TC_HIGH]), 256'(2));
    checkOutput("stats lohi", 256'(stats[TC_LOHI]), 256'(1));
    checkOutput("stats hilo", 256'(stats[TC_HILO]), 256'(1));
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6 out_valid", 256'(out_valid), 256'(0));
    checkOutput("t6 almost_full", 256'(almost_full), 256'(0));
    checkOutput("t6 errs", 256'({overflow_err, flag_err}), 256'(0));
    checkOutput("t6 out_data", 256'(out_data), 256'(0));
`ifdef TRAV_DECIDE_STATS_EN
    checkOutput("t6 stats", 256'(stats), 256'(0));
`endif

    applyStimulus(1'b1, 9'd77, 16'h0500, 4'b1000, ONE, FIVE, TWO);
    tick();
    idle();
    checkOutput("post-reset ray", 256'(out_data.ray_id), 256'(77));
    popOne();
    checkOutput("post-reset drained", 256'(out_valid), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
